// File: rtl/bus_buffer_pkg.sv
// ---------------------------------------------------------------------------
// bus_buffer_pkg
// Shared definitions for the bus buffer controller:
//   - default values for the DATA_W, FIFO_DEPTH and SYNC_STAGES parameters
//   - the FSM state encoding (state_e)
// ---------------------------------------------------------------------------
package bus_buffer_pkg;

    localparam int DEFAULT_DATA_W      = 8;
    localparam int DEFAULT_FIFO_DEPTH  = 4;
    localparam int DEFAULT_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WRITE      = 2'd1,
        ST_READ_WAIT  = 2'd2,
        ST_READ_DRIVE = 2'd3
    } state_e;

endpackage

// File: rtl/bus_buffer_ctrl_if.sv
// ---------------------------------------------------------------------------
// bus_buffer_ctrl_if
// Groups the external strobe/data bus and the core-side FIFO and read
// handshakes of bus_buffer_ctrl.
//   External bus : cs_n, rd_n, wr_n, a0, bus_in  -> controller
//                  bus_out, bus_oe               <- controller
//   Write FIFO   : wr_valid, wr_data             <- controller
//                  wr_ready                      -> controller
//   Read request : rd_req, rd_a0                 <- controller
//                  rd_data, rd_ack               -> controller
// Modports: slave = the controller, master = its environment.
// ---------------------------------------------------------------------------
interface bus_buffer_ctrl_if #(
    parameter int DATA_W = bus_buffer_pkg::DEFAULT_DATA_W
);
    logic              cs_n;
    logic              rd_n;
    logic              wr_n;
    logic              a0;
    logic [DATA_W-1:0] bus_in;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;

    logic              wr_valid;
    logic [DATA_W:0]   wr_data;
    logic              wr_ready;

    logic              rd_req;
    logic              rd_a0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ack;

    modport slave (
        input  cs_n, rd_n, wr_n, a0, bus_in, wr_ready, rd_data, rd_ack,
        output bus_out, bus_oe, wr_valid, wr_data, rd_req, rd_a0
    );

    modport master (
        output cs_n, rd_n, wr_n, a0, bus_in, wr_ready, rd_data, rd_ack,
        input  bus_out, bus_oe, wr_valid, wr_data, rd_req, rd_a0
    );
endinterface

// File: rtl/bus_buffer_fifo.sv
// ---------------------------------------------------------------------------
// bus_buffer_fifo
// Synchronous FIFO, first-word-fall-through (head is always visible).
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push/data  : write push_data when push=1 and there is room or a pop
//                happens in the same cycle
//   pop        : drop the head; ignored while empty
//   head       : oldest entry
//   full/empty : occupancy flags
//   count      : occupancy, $clog2(DEPTH)+1 bits
// DEPTH must be a power of two (pointers wrap naturally).
// ---------------------------------------------------------------------------
module bus_buffer_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign head  = mem[rd_ptr];

    // A pop frees the slot a same-cycle push needs, so full+pop still accepts.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read after
    // it has been written, and leaving it out keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bus_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// bus_buffer_ctrl
// Bridges an asynchronous strobe bus (cs_n/rd_n/wr_n/a0) to a synchronous core.
// Writes are captured into a hold register and committed to a FIFO on the
// trailing edge of wr; reads issue a one-cycle rd_req, wait for rd_ack, and
// drive the latched data onto the bus until rd is released.
//   clk, reset : clock, synchronous active-high reset
//   bus        : bus_buffer_ctrl_if.slave (external bus + core handshakes)
//   ovf        : sticky, a write was dropped because the FIFO was full
//   err        : sticky, rd and wr were active together under cs
//   clr_flags  : clears ovf and err (a same-cycle set event wins)
// ---------------------------------------------------------------------------
module bus_buffer_ctrl
    import bus_buffer_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              reset,
    bus_buffer_ctrl_if.slave  bus,
    output logic              ovf,
    output logic              err,
    input  logic              clr_flags
);
    localparam logic [1:0] IDLE       = ST_IDLE;
    localparam logic [1:0] WRITE      = ST_WRITE;
    localparam logic [1:0] READ_WAIT  = ST_READ_WAIT;
    localparam logic [1:0] READ_DRIVE = ST_READ_DRIVE;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Per stage: {cs_n, rd_n, wr_n}; the oldest stage is the synchronised view.
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic                        cs_act;
    logic                        rd_act;
    logic                        wr_act;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [DATA_W:0]   hold_q;
    logic [DATA_W-1:0] latch_q;
    logic              rd_req_q;
    logic              rd_a0_q;

    logic              push;
    logic              hold_en;
    logic              latch_en;
    logic              rd_start;
    logic              err_evt;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              pop;
    logic              ovf_evt;

    assign cs_act = ~sync_q[SYNC_STAGES-1][2];
    assign rd_act = ~sync_q[SYNC_STAGES-1][1];
    assign wr_act = ~sync_q[SYNC_STAGES-1][0];

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        push     = 1'b0;
        hold_en  = 1'b0;
        latch_en = 1'b0;
        rd_start = 1'b0;
        err_evt  = 1'b0;

        if (cs_act && rd_act && wr_act) begin
            err_evt = 1'b1;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_act && wr_act) begin
                        state_d = WRITE;
                        hold_en = 1'b1;
                    end else if (cs_act && rd_act) begin
                        state_d  = READ_WAIT;
                        rd_start = 1'b1;
                    end
                end
                WRITE: begin
                    if (!cs_act) begin
                        state_d = IDLE;
                    end else if (!wr_act) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        hold_en = 1'b1;
                    end
                end
                READ_WAIT: begin
                    // Release beats a same-cycle ack: the read was abandoned.
                    if (!cs_act || !rd_act) begin
                        state_d = IDLE;
                    end else if (bus.rd_ack) begin
                        latch_en = 1'b1;
                        state_d  = READ_DRIVE;
                    end
                end
                READ_DRIVE: begin
                    if (!cs_act || !rd_act) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign pop     = bus.wr_ready & ~fifo_empty;
    assign ovf_evt = push & fifo_full & ~pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '1;
            state_q  <= IDLE;
            hold_q   <= '0;
            latch_q  <= '0;
            rd_req_q <= 1'b0;
            rd_a0_q  <= 1'b0;
            ovf      <= 1'b0;
            err      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value; blocking here would collapse the synchroniser.
            sync_q   <= {sync_q[SYNC_STAGES-2:0], {bus.cs_n, bus.rd_n, bus.wr_n}};
            state_q  <= state_d;
            rd_req_q <= rd_start;
            if (rd_start) rd_a0_q <= bus.a0;
            if (hold_en)  hold_q  <= {bus.a0, bus.bus_in};
            if (latch_en) latch_q <= bus.rd_data;

            if (ovf_evt)        ovf <= 1'b1;
            else if (clr_flags) ovf <= 1'b0;
            if (err_evt)        err <= 1'b1;
            else if (clr_flags) err <= 1'b0;
        end
    end

    bus_buffer_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (hold_q),
        .pop       (pop),
        .head      (bus.wr_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.wr_valid = ~fifo_empty;
    assign bus.bus_out  = latch_q;
    assign bus.bus_oe   = (state_q == READ_DRIVE);
    assign bus.rd_req   = rd_req_q;
    assign bus.rd_a0    = rd_a0_q;

    a_count_bound : assert property (@(posedge clk) disable iff (reset)
        fifo_count <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_bus_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bus_buffer_ctrl
// Directed scenarios followed by a randomised sequence of bus writes, reads,
// core pops and flag clears, each compared with a transaction-level model
// (queue of committed writes, sticky flags, last read value).
// ---------------------------------------------------------------------------
module tb_bus_buffer_ctrl;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    logic clr_flags;
    logic ovf;
    logic err;

    always #5 clk = ~clk;

    bus_buffer_ctrl_if #(.DATA_W(DW)) bif ();

    bus_buffer_ctrl #(
        .DATA_W      (DW),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bif),
        .ovf       (ovf),
        .err       (err),
        .clr_flags (clr_flags)
    );

    // Reference model state
    logic [DW:0]   exp_q[$];
    logic          exp_ovf;
    logic          exp_err;
    logic [DW-1:0] exp_latch;

    int tests_run    = 0;
    int tests_failed = 0;
    int rd_req_cnt   = 0;

    always @(negedge clk) if (bif.rd_req === 1'b1) rd_req_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_valid"}, 32'(bif.wr_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) check({tag, "_head"}, 32'(bif.wr_data), 32'(exp_q[0]));
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        exp_ovf   = 1'b0;
        exp_err   = 1'b0;
        exp_latch = '0;
    endtask

    task automatic idle_bus();
        bif.cs_n = 1'b1; bif.rd_n = 1'b1; bif.wr_n = 1'b1;
        bif.wr_ready = 1'b0; bif.rd_ack = 1'b0; clr_flags = 1'b0;
    endtask

    // mode 0: plain write; 1: core pops in the commit cycle; 2: clr_flags in
    // the commit cycle. The commit lands 3 edges after wr_n rises
    // (2 synchroniser stages + 1 clk).
    task automatic do_write(input logic a0, input logic [DW-1:0] d, input int mode);
        bit pop_now;
        bif.a0 = a0; bif.bus_in = d; bif.cs_n = 1'b0;
        @(negedge clk);
        bif.wr_n = 1'b0;
        repeat (3 + $urandom_range(0, 3)) @(negedge clk);
        bif.wr_n = 1'b1;
        repeat (2) @(negedge clk);
        pop_now = (mode == 1) && (exp_q.size() != 0);
        if (mode == 1) begin
            bif.wr_ready = 1'b1;
            if (pop_now) check("commit_pop_head", 32'(bif.wr_data), 32'(exp_q[0]));
        end
        if (mode == 2) clr_flags = 1'b1;
        @(negedge clk);
        bif.wr_ready = 1'b0; clr_flags = 1'b0;
        if (mode == 2) begin exp_ovf = 1'b0; exp_err = 1'b0; end
        if (pop_now) void'(exp_q.pop_front());
        if (exp_q.size() < DEPTH) exp_q.push_back({a0, d});
        else exp_ovf = 1'b1;
        bif.cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check_status("write");
    endtask

    task automatic do_read(input logic a0, input logic [DW-1:0] d, input int ack_dly, input bit abort);
        int  base = rd_req_cnt;
        bit  seen = 1'b0;
        int  oe_hi = 0;
        bif.a0 = a0; bif.cs_n = 1'b0;
        @(negedge clk);
        bif.rd_n = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bif.rd_req === 1'b1) seen = 1'b1;
        end
        check("rd_req_seen", 32'(seen), 32'd1);
        check("rd_a0", 32'(bif.rd_a0), 32'(a0));
        if (abort) begin
            bif.rd_n = 1'b1;
            repeat (2) @(negedge clk);
            bif.rd_ack = 1'b1; bif.rd_data = d;
            @(negedge clk);
            bif.rd_ack = 1'b0; bif.rd_data = ~d;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (bif.bus_oe !== 1'b0) oe_hi++;
            end
            check("abort_oe_low", 32'(oe_hi), 32'd0);
            check("abort_latch", 32'(bif.bus_out), 32'(exp_latch));
        end else begin
            repeat (ack_dly) @(negedge clk);
            bif.rd_ack = 1'b1; bif.rd_data = d;
            @(negedge clk);
            bif.rd_ack = 1'b0; bif.rd_data = ~d;
            exp_latch = d;
            seen = 1'b0;
            for (int i = 0; i < 5 && !seen; i++) begin
                if (bif.bus_oe === 1'b1) seen = 1'b1;
                else @(negedge clk);
            end
            check("read_oe_high", 32'(seen), 32'd1);
            check("read_bus_out", 32'(bif.bus_out), 32'(d));
            repeat (2) @(negedge clk);
            check("read_oe_held", 32'(bif.bus_oe), 32'd1);
            bif.rd_n = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 6 && !seen; i++) begin
                @(negedge clk);
                if (bif.bus_oe === 1'b0) seen = 1'b1;
            end
            check("read_oe_release", 32'(seen), 32'd1);
            check("read_latch_kept", 32'(bif.bus_out), 32'(d));
        end
        bif.cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rd_req_once", 32'(rd_req_cnt - base), 32'd1);
    endtask

    task automatic do_pop();
        bif.wr_ready = 1'b1;
        @(negedge clk);
        bif.wr_ready = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        check_status("pop");
    endtask

    task automatic do_clear();
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        exp_ovf = 1'b0; exp_err = 1'b0;
        @(negedge clk);
        check_status("clear");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset = 1'b1;
        bif.a0 = 1'b0; bif.bus_in = '0; bif.rd_data = '0;
        idle_bus();
        @(negedge clk);
        apply_reset(3);

        // Reset state
        check("rst_bus_oe", 32'(bif.bus_oe), 32'd0);
        check("rst_bus_out", 32'(bif.bus_out), 32'd0);
        check("rst_rd_req", 32'(bif.rd_req), 32'd0);
        check("rst_rd_a0", 32'(bif.rd_a0), 32'd0);
        check_status("rst");

        // Single write, head stays valid until popped
        do_write(1'b1, 8'hAB, 0);
        check("w1_data", 32'(bif.wr_data), 32'h1AB);
        repeat (4) @(negedge clk);
        check("w1_valid_held", 32'(bif.wr_valid), 32'd1);
        do_pop();

        // Read with ack 3 clk after the request
        do_read(1'b0, 8'hCD, 3, 1'b0);

        // Overflow: five writes into a four-entry FIFO
        for (int i = 1; i <= 5; i++) do_write(1'b0, DW'(i), 0);
        for (int i = 0; i < DEPTH; i++) do_pop();
        do_clear();

        // Full FIFO: same-cycle push+pop accepted; set beats clear
        for (int i = 0; i < DEPTH; i++) do_write(1'b1, DW'(8'h10 + i), 0);
        do_write(1'b0, 8'h77, 1);
        do_write(1'b0, 8'h88, 0);
        do_write(1'b0, 8'h99, 2);
        do_clear();
        for (int i = 0; i < DEPTH; i++) do_pop();

        // Aborted read: late ack ignored
        do_read(1'b1, 8'hEE, 0, 1'b1);

        // Both strobes together
        base = rd_req_cnt;
        bif.cs_n = 1'b0;
        @(negedge clk);
        bif.rd_n = 1'b0; bif.wr_n = 1'b0;
        repeat (6) @(negedge clk);
        bif.rd_n = 1'b1; bif.wr_n = 1'b1;
        repeat (4) @(negedge clk);
        bif.cs_n = 1'b1;
        repeat (3) @(negedge clk);
        exp_err = 1'b1;
        check_status("both_strobes");
        check("both_no_rd_req", 32'(rd_req_cnt - base), 32'd0);
        do_clear();

        // Loss of cs mid-write
        bif.bus_in = 8'h3C; bif.cs_n = 1'b0;
        @(negedge clk);
        bif.wr_n = 1'b0;
        repeat (5) @(negedge clk);
        bif.cs_n = 1'b1;
        repeat (4) @(negedge clk);
        bif.wr_n = 1'b1;
        repeat (5) @(negedge clk);
        check_status("cs_loss");

        // Reset mid-write, strobe still held afterwards
        bif.a0 = 1'b1; bif.bus_in = 8'h5A; bif.cs_n = 1'b0;
        @(negedge clk);
        bif.wr_n = 1'b0;
        repeat (5) @(negedge clk);
        apply_reset(2);
        check("midrst_latch", 32'(bif.bus_out), 32'd0);
        repeat (5) @(negedge clk);
        check_status("midrst_held");
        bif.wr_n = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.push_back({1'b1, 8'h5A});
        check_status("midrst_commit");
        bif.cs_n = 1'b1;
        do_pop();

        // Randomised traffic
        for (int n = 0; n < 60; n++) begin
            int op = $urandom_range(0, 9);
            if (op <= 3)
                do_write(1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)), $urandom_range(0, 2));
            else if (op <= 6)
                do_read(1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)),
                        $urandom_range(0, 4), ($urandom_range(0, 3) == 0));
            else if (op <= 8)
                do_pop();
            else
                do_clear();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
